// File: rtl/micro_pkg.sv
// Shared encodings for the multicycle MIPS micro-sequencer.
// State numbers, sequencing codes, mux selects and control-word layout.
package micro_pkg;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_MEMADR = 2;
    localparam int S_MEMRD  = 3;
    localparam int S_MEMWB  = 4;
    localparam int S_MEMWR  = 5;
    localparam int S_EXEC   = 6;
    localparam int S_RDONE  = 7;
    localparam int S_BRANCH = 8;
    localparam int S_JUMP   = 9;
    localparam int S_LAST   = S_JUMP;

    localparam logic [1:0] AC_FETCH = 2'd0;
    localparam logic [1:0] AC_DISP1 = 2'd1;
    localparam logic [1:0] AC_DISP2 = 2'd2;
    localparam logic [1:0] AC_SEQ   = 2'd3;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JMP  = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_SH  = 2'b11;

    localparam int CW_PC_WRITE  = 0;
    localparam int CW_PC_WCOND  = 1;
    localparam int CW_I_OR_D    = 2;
    localparam int CW_MEM_READ  = 3;
    localparam int CW_MEM_WRITE = 4;
    localparam int CW_IR_WRITE  = 5;
    localparam int CW_MEM2REG   = 6;
    localparam int CW_REG_WRITE = 7;
    localparam int CW_REG_DST   = 8;
    localparam int CW_SRC_A     = 9;
    localparam int CW_PC_SRC    = 10;
    localparam int CW_ALU_OP    = 12;
    localparam int CW_SRC_B     = 14;
    localparam int CW_DONE      = 16;
    localparam int CW_W         = 17;

    // Legal decode targets are the execution entry states 2..9.
    function automatic logic disp1_ok(input logic [3:0] t);
        return (int'(t) >= S_MEMADR) && (int'(t) <= S_LAST);
    endfunction

    // Only lw (MEMRD) and sw (MEMWR) are legal memory-op targets.
    function automatic logic disp2_ok(input logic [3:0] t);
        return (int'(t) == S_MEMRD) || (int'(t) == S_MEMWR);
    endfunction

endpackage

// File: rtl/micro_rom.sv
// Combinational control store: micro-PC to control word and addr_ctl.
// Unreachable micro-addresses yield an all-zero word and return to fetch.
module micro_rom
    import micro_pkg::*;
#(
    parameter int UPC_W = 4
) (
    input  logic [UPC_W-1:0] upc_i,
    output logic [CW_W-1:0]  cw_o,
    output logic [1:0]       addr_ctl_o
);

    // Decode one micro-state into its control word.
    always_comb begin
        cw_o       = '0;
        addr_ctl_o = AC_FETCH;
        case (int'(upc_i))
            S_FETCH: begin
                cw_o[CW_MEM_READ]          = 1'b1;
                cw_o[CW_IR_WRITE]          = 1'b1;
                cw_o[CW_PC_WRITE]          = 1'b1;
                cw_o[CW_SRC_B +: 2]        = SRCB_4;
                addr_ctl_o                 = AC_SEQ;
            end
            S_DECODE: begin
                cw_o[CW_SRC_B +: 2]        = SRCB_SH;
                addr_ctl_o                 = AC_DISP1;
            end
            S_MEMADR: begin
                cw_o[CW_SRC_A]             = 1'b1;
                cw_o[CW_SRC_B +: 2]        = SRCB_IMM;
                addr_ctl_o                 = AC_DISP2;
            end
            S_MEMRD: begin
                cw_o[CW_MEM_READ]          = 1'b1;
                cw_o[CW_I_OR_D]            = 1'b1;
                addr_ctl_o                 = AC_SEQ;
            end
            S_MEMWB: begin
                cw_o[CW_REG_WRITE]         = 1'b1;
                cw_o[CW_MEM2REG]           = 1'b1;
                cw_o[CW_DONE]              = 1'b1;
            end
            S_MEMWR: begin
                cw_o[CW_MEM_WRITE]         = 1'b1;
                cw_o[CW_I_OR_D]            = 1'b1;
                cw_o[CW_DONE]              = 1'b1;
            end
            S_EXEC: begin
                cw_o[CW_SRC_A]             = 1'b1;
                cw_o[CW_ALU_OP +: 2]       = ALU_FUNC;
                addr_ctl_o                 = AC_SEQ;
            end
            S_RDONE: begin
                cw_o[CW_REG_DST]           = 1'b1;
                cw_o[CW_REG_WRITE]         = 1'b1;
                cw_o[CW_DONE]              = 1'b1;
            end
            S_BRANCH: begin
                cw_o[CW_SRC_A]             = 1'b1;
                cw_o[CW_ALU_OP +: 2]       = ALU_SUB;
                cw_o[CW_PC_WCOND]          = 1'b1;
                cw_o[CW_PC_SRC +: 2]       = PCS_OUT;
                cw_o[CW_DONE]              = 1'b1;
            end
            S_JUMP: begin
                cw_o[CW_PC_WRITE]          = 1'b1;
                cw_o[CW_PC_SRC +: 2]       = PCS_JMP;
                cw_o[CW_DONE]              = 1'b1;
            end
            default: begin
                cw_o       = '0;
                addr_ctl_o = AC_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC register, next-address mux and retired-instruction counter.
// Define MICRO_SEQ_MEM_WAIT_EN to stall memory states on mem_ready.
module micro_sequencer
    import micro_pkg::*;
#(
    parameter int UPC_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       dispatch1,
    input  logic [3:0]       dispatch2,
    input  logic             mem_ready,
    output logic [UPC_W-1:0] upc,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [UPC_W-1:0] upc_q, upc_d, nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW_W-1:0]  cw;
    logic [1:0]       addr_ctl;
    logic             stall;
    logic             ready_gate;

    micro_rom #(.UPC_W(UPC_W)) u_rom (
        .upc_i      (upc_q),
        .cw_o       (cw),
        .addr_ctl_o (addr_ctl)
    );

    // Select the next micro-address; illegal dispatch targets refetch.
    always_comb begin
        nxt = '0;
        unique case (addr_ctl)
            AC_SEQ:   nxt = upc_q + 1'b1;
            AC_DISP1: nxt = disp1_ok(dispatch1) ? UPC_W'(dispatch1) : '0;
            AC_DISP2: nxt = disp2_ok(dispatch2) ? UPC_W'(dispatch2) : '0;
            default:  nxt = '0;
        endcase
    end

`ifdef MICRO_SEQ_MEM_WAIT_EN
    // Memory states hold until the memory handshake completes.
    always_comb begin
        stall = 1'b0;
        if (int'(upc_q) == S_FETCH || int'(upc_q) == S_MEMRD ||
            int'(upc_q) == S_MEMWR)
            stall = !mem_ready;
    end
`else
    // Memory is assumed single-cycle; mem_ready is unused.
    always_comb begin
        stall = 1'b0;
        if (mem_ready && 1'b0)
            stall = 1'b1;
    end
`endif

    assign ready_gate = !stall;

    // Drive control outputs; side-effecting strobes wait for memory.
    always_comb begin
        pc_write      = cw[CW_PC_WRITE] & ready_gate;
        pc_write_cond = cw[CW_PC_WCOND];
        i_or_d        = cw[CW_I_OR_D];
        mem_read      = cw[CW_MEM_READ];
        mem_write     = cw[CW_MEM_WRITE];
        ir_write      = cw[CW_IR_WRITE] & ready_gate;
        mem_to_reg    = cw[CW_MEM2REG];
        reg_write     = cw[CW_REG_WRITE];
        reg_dst       = cw[CW_REG_DST];
        alu_src_a     = cw[CW_SRC_A];
        pc_source     = cw[CW_PC_SRC +: 2];
        alu_op        = cw[CW_ALU_OP +: 2];
        alu_src_b     = cw[CW_SRC_B +: 2];
        instr_done    = cw[CW_DONE] & ready_gate;
    end

    // Next-state values for the micro-PC and the retire counter.
    always_comb begin
        upc_d = stall ? upc_q : nxt;
        cnt_d = instr_done ? cnt_q + 1'b1 : cnt_q;
    end

    // State registers; reset abandons any partial instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_q <= '0;
            cnt_q <= '0;
        end else begin
            upc_q <= upc_d;
            cnt_q <= cnt_d;
        end
    end

    assign upc       = upc_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed-vector bench for micro_sequencer.
// Build with MICRO_SEQ_MEM_WAIT_EN to also exercise the memory stall.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dispatch1;
    logic [3:0]  dispatch2;
    logic        mem_ready;
    logic [3:0]  upc;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic        ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0]  pc_source, alu_op, alu_src_b;
    logic        instr_done;
    logic [31:0] instr_cnt;

    int nvec = 0;
    int nerr = 0;

    micro_sequencer #(.UPC_W(4), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .dispatch1     (dispatch1),
        .dispatch2     (dispatch2),
        .mem_ready     (mem_ready),
        .upc           (upc),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .alu_src_b     (alu_src_b),
        .instr_done    (instr_done),
        .instr_cnt     (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Walk one instruction, checking the micro-address after each edge.
    task automatic run(input string tag, input int n, input int seq[6]);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, 32'(upc), 32'(seq[i]));
        end
    endtask

    int exp_cnt;

    initial begin
        rst       = 1'b0;
        dispatch1 = 4'd0;
        dispatch2 = 4'd0;
        mem_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_upc", 32'(upc), 0);
        check("rst_cnt", instr_cnt, 0);
        check("fetch_mr", 32'(mem_read), 1);
        check("fetch_irw", 32'(ir_write), 1);
        check("fetch_pcw", 32'(pc_write), 1);
        check("fetch_srcb", 32'(alu_src_b), 1);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;

        // lw
        dispatch1 = 4'd2;
        dispatch2 = 4'd3;
        step(); check("lw_s1", 32'(upc), 1);
        check("dec_srcb", 32'(alu_src_b), 3);
        step(); check("lw_s2", 32'(upc), 2);
        check("adr_srca", 32'(alu_src_a), 1);
        check("adr_srcb", 32'(alu_src_b), 2);
        step(); check("lw_s3", 32'(upc), 3);
        check("rd_iord", 32'(i_or_d), 1);
        check("rd_mr", 32'(mem_read), 1);
        step(); check("lw_s4", 32'(upc), 4);
        check("wb_m2r", 32'(mem_to_reg), 1);
        check("wb_rw", 32'(reg_write), 1);
        check("wb_done", 32'(instr_done), 1);
        check("wb_cnt", instr_cnt, 0);
        step(); check("lw_s0", 32'(upc), 0);
        exp_cnt++;
        check("lw_cnt", instr_cnt, 32'(exp_cnt));

        // sw
        dispatch2 = 4'd5;
        run("sw", 3, '{1, 2, 5, 0, 0, 0});
        check("sw_mw", 32'(mem_write), 1);
        check("sw_done", 32'(instr_done), 1);
        step(); check("sw_s0", 32'(upc), 0);
        check("sw_mw0", 32'(mem_write), 0);
        exp_cnt++;
        check("sw_cnt", instr_cnt, 32'(exp_cnt));

        // R-type
        dispatch1 = 4'd6;
        run("rt", 2, '{1, 6, 0, 0, 0, 0});
        check("ex_aluop", 32'(alu_op), 2);
        check("ex_done", 32'(instr_done), 0);
        step(); check("rt_s7", 32'(upc), 7);
        check("rd_dst", 32'(reg_dst), 1);
        check("rd_rw", 32'(reg_write), 1);
        step(); check("rt_s0", 32'(upc), 0);
        exp_cnt++;
        check("rt_cnt", instr_cnt, 32'(exp_cnt));

        // beq
        dispatch1 = 4'd8;
        run("beq", 2, '{1, 8, 0, 0, 0, 0});
        check("beq_pwc", 32'(pc_write_cond), 1);
        check("beq_pcs", 32'(pc_source), 1);
        check("beq_aluop", 32'(alu_op), 1);
        check("beq_pcw", 32'(pc_write), 0);
        step(); check("beq_s0", 32'(upc), 0);
        exp_cnt++;
        check("beq_cnt", instr_cnt, 32'(exp_cnt));

        // j
        dispatch1 = 4'd9;
        run("j", 2, '{1, 9, 0, 0, 0, 0});
        check("j_pcw", 32'(pc_write), 1);
        check("j_pcs", 32'(pc_source), 2);
        step(); check("j_s0", 32'(upc), 0);
        exp_cnt++;
        check("j_cnt", instr_cnt, 32'(exp_cnt));

        // illegal dispatch targets
        dispatch1 = 4'd0;
        run("ill0", 2, '{1, 0, 0, 0, 0, 0});
        dispatch1 = 4'd1;
        run("ill1", 2, '{1, 0, 0, 0, 0, 0});
        dispatch1 = 4'd10;
        run("ill10", 2, '{1, 0, 0, 0, 0, 0});
        dispatch1 = 4'd2;
        dispatch2 = 4'd0;
        run("ill_d2", 3, '{1, 2, 0, 0, 0, 0});
        dispatch2 = 4'd4;
        run("ill_d2b", 3, '{1, 2, 0, 0, 0, 0});
        check("ill_cnt", instr_cnt, 32'(exp_cnt));

        // async reset in MEMRD
        dispatch2 = 4'd3;
        run("pre_rst", 3, '{1, 2, 3, 0, 0, 0});
        #2 rst = 1'b1;
        #1;
        check("arst_upc", 32'(upc), 0);
        check("arst_cnt", instr_cnt, 0);
        #1 rst = 1'b0;
        run("post_rst", 5, '{1, 2, 3, 4, 0, 0});
        check("post_cnt", instr_cnt, 1);

`ifdef MICRO_SEQ_MEM_WAIT_EN
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wt_upc", 32'(upc), 0);
            check("wt_pcw", 32'(pc_write), 0);
            check("wt_irw", 32'(ir_write), 0);
            check("wt_mr", 32'(mem_read), 1);
        end
        mem_ready = 1'b1;
        #1;
        check("wt_pulse", 32'(pc_write), 1);
        step();
        check("wt_adv", 32'(upc), 1);
        check("wt_pcw1", 32'(pc_write), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
